// File: rtl/seg_scan_arbiter.sv
// Two-requester display arbiter with minimum hold time.
// Drives a time-multiplexed six-digit hex display with leading-zero blanking.
module seg_scan_arbiter #(
  parameter int SCAN_DIV    = 50000,
  parameter int HOLD_CYCLES = 50000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        a_valid,
  input  logic [23:0] a_data,
  output logic        a_ready,
  input  logic        b_valid,
  input  logic [23:0] b_data,
  output logic        b_ready,
  input  logic        blank_lz,
  output logic [3:0]  dig_bin,
  output logic [5:0]  dig_sel,
  output logic [23:0] disp_value,
  output logic        busy,
  output logic        owner_a
);

  localparam int HW = $clog2(HOLD_CYCLES);
  localparam int PW = $clog2(SCAN_DIV);
  localparam logic [HW-1:0] HOLD_LD = HW'(HOLD_CYCLES - 1);
  localparam logic [PW-1:0] PRE_MAX = PW'(SCAN_DIV - 1);

  typedef enum logic {
    S_IDLE,
    S_HOLD
  } state_t;

  state_t        r_state;
  state_t        w_state_nx;
  logic [HW-1:0] r_cnt;
  logic [HW-1:0] w_cnt_nx;
  logic [23:0]   r_disp;
  logic [23:0]   w_disp_nx;
  logic          r_owner;
  logic          w_owner_nx;
  logic [PW-1:0] r_pre;
  logic [2:0]    r_idx;
  logic          w_acc_a;
  logic          w_acc_b;
  logic [23:0]   w_shift;
  logic          w_blank;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_disp  <= '0;
      r_owner <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      r_disp  <= w_disp_nx;
      r_owner <= w_owner_nx;
    end
  end

  // A may cut into a B hold; nothing cuts into an A hold.
  always_comb begin
    a_ready    = (r_state == S_IDLE) || !r_owner;
    b_ready    = (r_state == S_IDLE) && !a_valid;
    w_acc_a    = a_valid && a_ready;
    w_acc_b    = b_valid && b_ready;
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_disp_nx  = r_disp;
    w_owner_nx = r_owner;
    if (w_acc_a) begin
      w_state_nx = S_HOLD;
      w_cnt_nx   = HOLD_LD;
      w_disp_nx  = a_data;
      w_owner_nx = 1'b1;
    end else if (w_acc_b) begin
      w_state_nx = S_HOLD;
      w_cnt_nx   = HOLD_LD;
      w_disp_nx  = b_data;
      w_owner_nx = 1'b0;
    end else if (r_state == S_HOLD) begin
      if (r_cnt == '0) begin
        w_state_nx = S_IDLE;
      end else begin
        w_cnt_nx = r_cnt - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pre <= '0;
      r_idx <= '0;
    end else if (r_pre == PRE_MAX) begin
      r_pre <= '0;
      r_idx <= (r_idx == 3'd5) ? 3'd0 : r_idx + 3'd1;
    end else begin
      r_pre <= r_pre + 1'b1;
    end
  end

  // Shifted value is zero exactly when nibbles idx..5 are all zero.
  assign w_shift    = r_disp >> {r_idx, 2'b00};
  assign w_blank    = blank_lz && (r_idx != 3'd0) && (w_shift == 24'd0);
  assign dig_bin    = w_shift[3:0];
  assign dig_sel    = w_blank ? 6'b000000 : (6'b000001 << r_idx);
  assign disp_value = r_disp;
  assign busy       = (r_state == S_HOLD);
  assign owner_a    = r_owner;

endmodule

// File: tb/tb_seg_scan_arbiter.sv
// Randomized and directed bench for seg_scan_arbiter.
// Reference model tracks remaining hold cycles and elapsed scan time.
module tb_seg_scan_arbiter;

  localparam int SD = 4;
  localparam int HC = 10;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_valid;
  logic [23:0] a_data;
  logic        a_ready;
  logic        b_valid;
  logic [23:0] b_data;
  logic        b_ready;
  logic        blank_lz;
  logic [3:0]  dig_bin;
  logic [5:0]  dig_sel;
  logic [23:0] disp_value;
  logic        busy;
  logic        owner_a;

  int n_checks = 0;
  int n_err    = 0;

  int          m_rem;
  logic [23:0] m_disp;
  logic        m_owner;
  int          m_t;

  seg_scan_arbiter #(.SCAN_DIV(SD), .HOLD_CYCLES(HC)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_data(b_data), .b_ready(b_ready),
    .blank_lz(blank_lz), .dig_bin(dig_bin), .dig_sel(dig_sel),
    .disp_value(disp_value), .busy(busy), .owner_a(owner_a)
  );

  always #5 clk = ~clk;

  function automatic logic exp_aready();
    return (m_rem == 0) || !m_owner;
  endfunction

  function automatic logic exp_bready();
    return (m_rem == 0) && !a_valid;
  endfunction

  function automatic int cur_idx();
    return (m_t / SD) % 6;
  endfunction

  function automatic logic [3:0] exp_bin();
    logic [23:0] v;
    v = m_disp >> (4 * cur_idx());
    return v[3:0];
  endfunction

  function automatic logic [5:0] exp_sel();
    int i;
    i = cur_idx();
    if (blank_lz && i > 0 && (m_disp >> (4 * i)) == 24'd0) return 6'd0;
    return 6'(1 << i);
  endfunction

  task automatic tick();
    logic acc_a, acc_b;
    acc_a = !rst && a_valid && exp_aready();
    acc_b = !rst && b_valid && exp_bready() && !acc_a;
    @(posedge clk);
    if (rst) begin
      m_rem = 0; m_disp = '0; m_owner = 1'b0; m_t = 0;
    end else begin
      m_t = (m_t + 1) % (6 * SD);
      if (acc_a) begin
        m_rem = HC; m_disp = a_data; m_owner = 1'b1;
      end else if (acc_b) begin
        m_rem = HC; m_disp = b_data; m_owner = 1'b0;
      end else if (m_rem > 0) begin
        m_rem--;
      end
    end
    #1;
  endtask

  task automatic idle_inputs();
    a_valid = 0; b_valid = 0; a_data = '0; b_data = '0;
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (busy && k < 40) begin
      tick(); k++;
    end
    n_checks++;
    if (busy !== 1'b0) begin
      n_err++; $display("FAIL wait_idle busy=%b want 0", busy);
    end
  endtask

  task automatic test_reset();
    idle_inputs(); blank_lz = 0; rst = 1; a_valid = 1;
    tick(); tick();
    rst = 0;
    #1;
    n_checks++;
    if ({dig_sel, dig_bin, busy, disp_value, owner_a} !== {6'b000001, 4'h0, 1'b0, 24'h0, 1'b0}) begin
      n_err++;
      $display("FAIL reset_state sel=%b bin=%h busy=%b disp=%h own=%b", dig_sel, dig_bin, busy, disp_value, owner_a);
    end
    n_checks++;
    if ({a_ready, b_ready} !== 2'b10) begin
      n_err++; $display("FAIL reset_ready_avalid got %b want 10", {a_ready, b_ready});
    end
    a_valid = 0;
    #1;
    n_checks++;
    if ({a_ready, b_ready} !== 2'b11) begin
      n_err++; $display("FAIL reset_ready_idle got %b want 11", {a_ready, b_ready});
    end
  endtask

  task automatic test_b_hold();
    b_valid = 1; b_data = 24'h00003C;
    #1;
    n_checks++;
    if (b_ready !== 1'b1) begin
      n_err++; $display("FAIL b_hold_ready got %b want 1", b_ready);
    end
    tick();
    b_valid = 0;
    n_checks++;
    if (disp_value !== 24'h00003C || owner_a !== 1'b0) begin
      n_err++; $display("FAIL b_hold_value got %h/%b want 00003c/0", disp_value, owner_a);
    end
    for (int i = 0; i < HC; i++) begin
      n_checks++;
      if (busy !== 1'b1) begin
        n_err++; $display("FAIL b_hold_busy cycle %0d got %b want 1", i, busy);
      end
      tick();
    end
    n_checks++;
    if (busy !== 1'b0 || disp_value !== 24'h00003C) begin
      n_err++; $display("FAIL b_hold_end busy=%b disp=%h want 0/00003c", busy, disp_value);
    end
  endtask

  task automatic test_simultaneous();
    a_valid = 1; a_data = 24'hEEEE01; b_valid = 1; b_data = 24'h000045;
    #1;
    n_checks++;
    if ({a_ready, b_ready} !== 2'b10) begin
      n_err++; $display("FAIL simul_ready got %b want 10", {a_ready, b_ready});
    end
    tick();
    idle_inputs();
    n_checks++;
    if (owner_a !== 1'b1 || disp_value !== 24'hEEEE01) begin
      n_err++; $display("FAIL simul_owner got %b/%h want 1/eeee01", owner_a, disp_value);
    end
    n_checks++;
    if (a_ready !== 1'b0) begin
      n_err++; $display("FAIL simul_a_locked got %b want 0", a_ready);
    end
    wait_idle();
  endtask

  task automatic test_preempt();
    b_valid = 1; b_data = 24'h000077;
    tick();
    b_valid = 0;
    tick(); tick(); tick();
    a_valid = 1; a_data = 24'h0000E1; b_valid = 1; b_data = 24'h000099;
    #1;
    n_checks++;
    if ({busy, a_ready, b_ready} !== 3'b110) begin
      n_err++; $display("FAIL preempt_ready got %b want 110", {busy, a_ready, b_ready});
    end
    tick();
    a_valid = 0;
    #1;
    n_checks++;
    if (disp_value !== 24'h0000E1 || owner_a !== 1'b1) begin
      n_err++; $display("FAIL preempt_value got %h/%b want 0000e1/1", disp_value, owner_a);
    end
    for (int i = 0; i < HC; i++) begin
      n_checks++;
      if (busy !== 1'b1 || b_ready !== 1'b0) begin
        n_err++; $display("FAIL preempt_hold cycle %0d busy=%b b_ready=%b want 1/0", i, busy, b_ready);
      end
      tick();
    end
    n_checks++;
    if (busy !== 1'b0 || b_ready !== 1'b1) begin
      n_err++; $display("FAIL preempt_end busy=%b b_ready=%b want 0/1", busy, b_ready);
    end
    b_valid = 0;
  endtask

  task automatic load_value(input logic [23:0] v);
    wait_idle();
    b_valid = 1; b_data = v;
    tick();
    b_valid = 0;
    while (m_t != 0) tick();
  endtask

  task automatic test_scan();
    logic [5:0] es;
    logic [3:0] eb;
    blank_lz = 0;
    load_value(24'h123456);
    for (int k = 0; k < 6 * SD + 1; k++) begin
      es = 6'(1 << ((k / SD) % 6));
      eb = 4'(6 - (k / SD) % 6);
      n_checks++;
      if (dig_sel !== es || dig_bin !== eb) begin
        n_err++; $display("FAIL scan k=%0d sel=%b bin=%h want %b/%h", k, dig_sel, dig_bin, es, eb);
      end
      tick();
    end
  endtask

  task automatic test_blank();
    logic [5:0] es;
    logic [3:0] eb;
    int s;
    blank_lz = 1;
    load_value(24'h000045);
    for (int k = 0; k < 6 * SD; k++) begin
      s  = k / SD;
      es = (s < 2) ? 6'(1 << s) : 6'd0;
      eb = (s == 0) ? 4'h5 : (s == 1) ? 4'h4 : 4'h0;
      n_checks++;
      if (dig_sel !== es || (s < 2 && dig_bin !== eb)) begin
        n_err++; $display("FAIL blank45 k=%0d sel=%b bin=%h want %b/%h", k, dig_sel, dig_bin, es, eb);
      end
      tick();
    end
    load_value(24'h000000);
    for (int k = 0; k < 6 * SD; k++) begin
      es = (k < SD) ? 6'b000001 : 6'd0;
      n_checks++;
      if (dig_sel !== es || dig_bin !== 4'h0) begin
        n_err++; $display("FAIL blank0 k=%0d sel=%b bin=%h want %b/0", k, dig_sel, dig_bin, es);
      end
      tick();
    end
    blank_lz = 0;
  endtask

  task automatic test_reset_mid();
    a_valid = 1; a_data = 24'hABCDEF;
    tick();
    a_valid = 0;
    tick(); tick(); tick();
    rst = 1; a_valid = 1; a_data = 24'h111111;
    tick();
    rst = 0; a_valid = 0;
    #1;
    n_checks++;
    if ({disp_value, busy, dig_sel, owner_a} !== {24'h0, 1'b0, 6'b000001, 1'b0}) begin
      n_err++;
      $display("FAIL reset_mid disp=%h busy=%b sel=%b own=%b", disp_value, busy, dig_sel, owner_a);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      rst      = ($urandom_range(0, 59) == 0);
      a_valid  = ($urandom_range(0, 5) == 0);
      b_valid  = ($urandom_range(0, 2) == 0);
      a_data   = $urandom_range(0, 1) ? 24'($urandom) : 24'($urandom_range(0, 255));
      b_data   = $urandom_range(0, 1) ? 24'($urandom) : 24'($urandom_range(0, 4095));
      if ($urandom_range(0, 15) == 0) blank_lz = ~blank_lz;
      #1;
      n_checks++;
      if (a_ready !== exp_aready() || b_ready !== exp_bready() ||
          busy !== (m_rem > 0) || disp_value !== m_disp || owner_a !== m_owner ||
          dig_sel !== exp_sel() || dig_bin !== exp_bin()) begin
        n_err++;
        $display("FAIL random c=%0d ar=%b br=%b busy=%b disp=%h own=%b sel=%b bin=%h want %b %b %b %h %b %b %h",
                 c, a_ready, b_ready, busy, disp_value, owner_a, dig_sel, dig_bin,
                 exp_aready(), exp_bready(), m_rem > 0, m_disp, m_owner, exp_sel(), exp_bin());
      end
      tick();
    end
    rst = 0;
    idle_inputs();
  endtask

  initial begin
    m_rem = 0; m_disp = '0; m_owner = 0; m_t = 0;
    test_reset();
    test_b_hold();
    test_simultaneous();
    test_preempt();
    test_scan();
    test_blank();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/seg_scan_arbiter.md
SEG_SCAN_ARBITER -- requirements
Module: seg_scan_arbiter

Interface
REQ-001 The block SHALL have parameter SCAN_DIV, default 50000, giving the clock cycles per digit scan slot (minimum 2).
REQ-002 The block SHALL have parameter HOLD_CYCLES, default 50000000, giving the minimum display hold time per accepted value in cycles (minimum 2).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port a_valid, input, 1 bit: high-priority (status/error) requester has a value.
REQ-006 The block SHALL have port a_data, input, 24 bits: six hex nibbles from requester A; nibble 0 is the rightmost digit.
REQ-007 The block SHALL have port a_ready, output, 1 bit: requester A transfer accepted this cycle when high with a_valid.
REQ-008 The block SHALL have ports b_valid (input, 1), b_data (input, 24) and b_ready (output, 1): the low-priority (MIDI event) requester, with the same meanings as the A ports.
REQ-009 The block SHALL have port blank_lz, input, 1 bit: enables leading-zero blanking.
REQ-010 The block SHALL have port dig_bin, output, 4 bits: the nibble presented to the single shared hex-to-7-segment decoder.
REQ-011 The block SHALL have port dig_sel, output, 6 bits: one-hot active-high enable of the digit currently driven; all zero means the slot is blanked.
REQ-012 The block SHALL have port disp_value, output, 24 bits: the currently latched display value.
REQ-013 The block SHALL have port busy, output, 1 bit: high while the hold timer runs.
REQ-014 The block SHALL have port owner_a, output, 1 bit: high when the latched value came from requester A.

Function
REQ-015 The arbiter SHALL have two states: IDLE and HOLD.
REQ-016 a_ready SHALL be high in IDLE, and in HOLD when owner_a=0 (A preempts a B hold); it SHALL be low in HOLD when owner_a=1.
REQ-017 b_ready SHALL be high only in IDLE with a_valid=0; A wins simultaneous requests.
REQ-018 On any accept, disp_value and owner_a SHALL update on the next edge, the hold counter SHALL load HOLD_CYCLES-1, and the state SHALL become HOLD.
REQ-019 In HOLD without an accept, the counter SHALL decrement each cycle; with the counter at 0 the state SHALL return to IDLE on that edge, giving exactly HOLD_CYCLES cycles in HOLD.
REQ-020 An A preemption during a B hold SHALL reload the counter to HOLD_CYCLES-1 and keep the state HOLD.
REQ-021 busy SHALL equal (state==HOLD).
REQ-022 disp_value SHALL persist after HOLD ends until the next accept.
REQ-023 The prescaler SHALL count 0..SCAN_DIV-1 and wrap; at SCAN_DIV-1 the digit index SHALL advance 0,1,...,5,0 (wrap 5->0).
REQ-024 Accepts SHALL NOT affect the prescaler or the digit index.
REQ-025 dig_bin SHALL equal disp_value[4*idx+3:4*idx] combinationally from registered state, so a new value is visible on dig_bin the cycle after the accept.
REQ-026 With blanking inactive, dig_sel SHALL be 1<<idx.
REQ-027 A digit SHALL be blanked (dig_sel=0) when blank_lz=1, idx>0, and nibbles idx..5 of disp_value are all zero; digit 0 is never blanked.
REQ-028 The block SHALL NOT have combinational paths from a_valid/b_valid to any output except a_ready and b_ready.

Reset
REQ-029 While rst=1 at an edge, the block SHALL set: state IDLE, hold counter 0, disp_value 0, owner_a 0, prescaler 0, idx 0.
REQ-030 After reset, outputs SHALL be: dig_sel=6'b000001, dig_bin=0, busy=0, a_ready=1, b_ready=!a_valid.
REQ-031 Reset asserted mid-HOLD or mid-scan SHALL abort the hold and discard the latched value; any request presented in the reset cycle SHALL NOT be accepted.

Verification (SCAN_DIV=4, HOLD_CYCLES=10)
REQ-032 Bench SHALL cover: b_valid with b_data=24'h00003C in IDLE -> b_ready=1, next cycle disp_value=00003C, busy=1 for exactly 10 cycles, then busy=0 with the value retained.
REQ-033 Bench SHALL cover: a_valid and b_valid raised in the same cycle (A=24'hEEEE01, B=24'h000045) -> A accepted, b_ready=0, owner_a=1, disp_value=EEEE01.
REQ-034 Bench SHALL cover: A=24'h0000E1 at cycle 4 of a B hold -> accepted, counter reloaded, busy stays high 10 more cycles; B offered meanwhile -> b_ready=0 throughout.
REQ-035 Bench SHALL cover: disp_value=24'h123456 free-running -> idx advances every 4 cycles, dig_sel sequence 01,02,04,08,10,20,01, dig_bin sequence 6,5,4,3,2,1.
REQ-036 Bench SHALL cover: blank_lz=1, disp_value=24'h000045 -> dig_sel=0 in slots 2..5, digits 0/1 show 5/4; disp_value=0 -> only digit 0 enabled, showing 0.
REQ-037 Bench SHALL cover: rst pulsed mid-hold with a_valid=1 -> next cycle disp_value=0, busy=0, dig_sel=000001, no accept in the reset cycle.
